// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory arbiter. This includes the FSM state encoding,
// the load/store access-size (memop) codes, the last-grant/owner encoding and
// the bus widths.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    // Identifies both the requester granted most recently and the owner of
    // the single outstanding transaction. These are always the same requester.
    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_LS = 1'b1
    } grant_t;

    localparam logic [2:0] MEMOP_8B = 3'd1;
    localparam logic [2:0] MEMOP_4B = 3'd2;
    localparam logic [2:0] MEMOP_2B = 3'd3;
    localparam logic [2:0] MEMOP_1B = 3'd4;

endpackage

// File: rtl/wmask_gen.sv
// -----------------------------------------------------------------------------
// wmask_gen
// Byte write-mask decode for load/store accesses.
//   i_memop   [2:0] : access size code (mem_pkg MEMOP_*)
//   i_addr_lo [2:0] : byte offset within the 8-byte word
//   o_mask    [7:0] : byte enables
// A full-word access ignores the offset. Narrower accesses shift their base
// mask by the offset, and bits shifted past byte 7 are dropped. Unknown codes
// select no bytes.
// -----------------------------------------------------------------------------
module wmask_gen
    import mem_pkg::*;
(
    input  logic [2:0]        i_memop,
    input  logic [2:0]        i_addr_lo,
    output logic [MASK_W-1:0] o_mask
);

    logic [MASK_W-1:0] w_base;
    logic              w_full;

    always_comb begin
        w_base = 8'h00;
        w_full = 1'b0;
        case (i_memop)
            MEMOP_8B: w_full = 1'b1;
            MEMOP_4B: w_base = 8'h0F;
            MEMOP_2B: w_base = 8'h03;
            MEMOP_1B: w_base = 8'h01;
            default:  w_base = 8'h00;
        endcase
    end

    // The shift is evaluated in 8-bit context, so overflowing lanes fall off.
    assign o_mask = w_full ? 8'hFF : (w_base << i_addr_lo);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// This module arbitrates between the instruction-fetch port (read only) and the
// load/store port. Both ports share one downstream memory, and only one
// transaction is outstanding at a time.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req_valid/ready         fetch request handshake (ready only in IDLE)
//   if_addr      [63:0]        fetch address
//   if_rsp_valid, if_rdata     one-cycle fetch response strobe and held data
//   ls_req_valid/ready         load/store request handshake
//   ls_addr, ls_wdata [63:0]   load/store address and store data
//   ls_wen, ls_memop [2:0]     store enable and access size
//   ls_rsp_valid, ls_rdata     one-cycle load/store response strobe and data
//   mem_req_valid/ready        downstream request handshake
//   mem_addr, mem_wdata        downstream address and write data
//   mem_wen, mem_wmask [7:0]   downstream write enable and byte mask
//   mem_rsp_valid, mem_rdata   downstream response
//
// Sequence: IDLE (grant) -> REQ (hold request until accepted) -> WAIT
// (capture response data) -> RESP (one-cycle strobe to the owner) -> IDLE.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [2:0]        ls_memop,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wen,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    grant_t            r_last_grant;
    logic              w_grant_if;
    logic              w_grant_ls;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wen;
    logic [MASK_W-1:0] r_wmask;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic [MASK_W-1:0] w_ls_mask;

    wmask_gen u_wmask_gen (
        .i_memop   (ls_memop),
        .i_addr_lo (ls_addr[2:0]),
        .o_mask    (w_ls_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_if    = 1'b0;
        w_grant_ls    = 1'b0;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        mem_req_valid = 1'b0;
        if_rsp_valid  = 1'b0;
        ls_rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On contention, LSU wins when fetch was granted last. A lone request always wins.
                w_grant_ls   = ls_req_valid && (!if_req_valid || (r_last_grant == GRANT_IF));
                w_grant_if   = if_req_valid && !w_grant_ls;
                if_req_ready = w_grant_if;
                ls_req_ready = w_grant_ls;
                if (w_grant_if || w_grant_ls) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if_rsp_valid = (r_last_grant == GRANT_IF);
                ls_rsp_valid = (r_last_grant == GRANT_LS);
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The request fields are captured at grant and held through REQ. Response data
    // is written only to the owner's register, so the other port's data stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_IF;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_wmask      <= '0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
        end else begin
            if (w_grant_ls) begin
                r_last_grant <= GRANT_LS;
                r_addr       <= ls_addr;
                r_wdata      <= ls_wdata;
                r_wen        <= ls_wen;
                r_wmask      <= ls_wen ? w_ls_mask : '0;
            end else if (w_grant_if) begin
                r_last_grant <= GRANT_IF;
                r_addr       <= if_addr;
                r_wdata      <= '0;
                r_wen        <= 1'b0;
                r_wmask      <= '0;
            end
            if ((r_state == ST_WAIT) && mem_rsp_valid) begin
                if (r_last_grant == GRANT_IF) begin
                    r_if_rdata <= mem_rdata;
                end else begin
                    r_ls_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wen   = r_wen;
    assign mem_wmask = r_wmask;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_rsp_valid;
    logic [63:0] if_rdata;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [63:0] ls_addr;
    logic        ls_wen;
    logic [63:0] ls_wdata;
    logic [2:0]  ls_memop;
    logic        ls_rsp_valid;
    logic [63:0] ls_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wen;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    mem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rsp_valid  (if_rsp_valid),
        .if_rdata      (if_rdata),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_addr       (ls_addr),
        .ls_wen        (ls_wen),
        .ls_wdata      (ls_wdata),
        .ls_memop      (ls_memop),
        .ls_rsp_valid  (ls_rsp_valid),
        .ls_rdata      (ls_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wen       (mem_wen),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Starts in IDLE just after a falling edge and returns at the falling edge
    // of the following IDLE cycle. Requires immediate memory ready/response.
    task automatic ls_txn(input logic [63:0] addr, input logic wen,
                          input logic [2:0] memop, input logic [7:0] exp_mask);
        ls_addr      = addr;
        ls_wen       = wen;
        ls_memop     = memop;
        ls_wdata     = 64'hCAFE_0000_0000_0000 | addr;
        ls_req_valid = 1'b1;
        #1 chk($sformatf("ls_ready op%0d", memop), 64'(ls_req_ready), 64'd1);
        @(negedge clk);
        ls_req_valid = 1'b0;
        #1;
        chk($sformatf("mem_wen op%0d", memop), 64'(mem_wen), 64'(wen));
        chk($sformatf("mem_wmask op%0d a%0h", memop, addr[2:0]), 64'(mem_wmask), 64'(exp_mask));
        chk($sformatf("mem_addr op%0d", memop), mem_addr, addr);
        @(negedge clk);
        @(negedge clk);
        #1 chk($sformatf("ls_rsp op%0d", memop), 64'(ls_rsp_valid), 64'd1);
        @(negedge clk);
    endtask

    logic [63:0] rd_tab [3];
    logic        own_tab[3];

    initial begin
        rst_n = 1'b0;
        if_req_valid = 1'b0; if_addr = '0;
        ls_req_valid = 1'b0; ls_addr = '0; ls_wen = 1'b0; ls_wdata = '0; ls_memop = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        rd_tab[0] = 64'hAAAA_0000_0000_0001; own_tab[0] = 1'b1;
        rd_tab[1] = 64'hBBBB_0000_0000_0002; own_tab[1] = 1'b0;
        rd_tab[2] = 64'hCCCC_0000_0000_0003; own_tab[2] = 1'b1;

        // reset state
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst if_rsp_valid", 64'(if_rsp_valid), 64'd0);
        chk("rst ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
        chk("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst mem_addr", mem_addr, 64'd0);
        chk("rst if_rdata", if_rdata, 64'd0);
        chk("rst mem_wmask", 64'(mem_wmask), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // fetch read with immediate ready and response
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
        mem_rdata = 64'h1122_3344_5566_7788;
        if_addr = 64'h8000_0000; if_req_valid = 1'b1;
        #1;
        chk("fetch if_ready", 64'(if_req_ready), 64'd1);
        chk("fetch ls_ready", 64'(ls_req_ready), 64'd0);
        @(negedge clk);
        if_req_valid = 1'b0;
        #1;
        chk("fetch mem_req_valid", 64'(mem_req_valid), 64'd1);
        chk("fetch mem_addr", mem_addr, 64'h8000_0000);
        chk("fetch mem_wen", 64'(mem_wen), 64'd0);
        chk("fetch mem_wmask", 64'(mem_wmask), 64'd0);
        @(negedge clk);
        #1 chk("fetch rsp early", 64'(if_rsp_valid), 64'd0);
        @(negedge clk);
        #1;
        chk("fetch if_rsp_valid", 64'(if_rsp_valid), 64'd1);
        chk("fetch if_rdata", if_rdata, 64'h1122_3344_5566_7788);
        chk("fetch ls_rsp_valid", 64'(ls_rsp_valid), 64'd0);
        // mem_rsp_valid still high in IDLE: must be ignored
        @(negedge clk);
        #1;
        chk("idle stray if_rsp", 64'(if_rsp_valid), 64'd0);
        chk("idle if_rdata hold", if_rdata, 64'h1122_3344_5566_7788);
        @(negedge clk);
        #1 chk("idle stray ls_rsp", 64'(ls_rsp_valid), 64'd0);

        // round-robin from reset: LS, IF, LS
        rst_n = 1'b0;
        #1;
        chk("rst2 if_rdata", if_rdata, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        if_addr = 64'h100; ls_addr = 64'h200; ls_wen = 1'b0; ls_memop = 3'd1;
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        for (int g = 0; g < 3; g++) begin
            mem_rdata = rd_tab[g];
            #1;
            chk($sformatf("rr%0d ls_ready", g), 64'(ls_req_ready), 64'(own_tab[g]));
            chk($sformatf("rr%0d if_ready", g), 64'(if_req_ready), 64'(!own_tab[g]));
            @(negedge clk);
            if (g == 2) begin
                if_req_valid = 1'b0; ls_req_valid = 1'b0;
            end
            #1 chk($sformatf("rr%0d ready busy", g), 64'({if_req_ready, ls_req_ready}), 64'd0);
            @(negedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("rr%0d ls_rsp", g), 64'(ls_rsp_valid), 64'(own_tab[g]));
            chk($sformatf("rr%0d if_rsp", g), 64'(if_rsp_valid), 64'(!own_tab[g]));
            if (own_tab[g]) chk($sformatf("rr%0d ls_rdata", g), ls_rdata, rd_tab[g]);
            else            chk($sformatf("rr%0d if_rdata", g), if_rdata, rd_tab[g]);
            @(negedge clk);
        end
        chk("rr ls_rdata final", ls_rdata, 64'hCCCC_0000_0000_0003);
        chk("rr if_rdata held", if_rdata, 64'hBBBB_0000_0000_0002);

        // write masks
        ls_txn(64'h8000_0003, 1'b1, 3'd4, 8'h08);
        ls_txn(64'h8000_0003, 1'b1, 3'd1, 8'hFF);
        ls_txn(64'h8000_0003, 1'b1, 3'd0, 8'h00);
        ls_txn(64'h8000_0006, 1'b1, 3'd2, 8'hC0);
        ls_txn(64'h8000_0007, 1'b1, 3'd3, 8'h80);
        ls_txn(64'h8000_0005, 1'b1, 3'd3, 8'h60);
        ls_txn(64'h8000_0004, 1'b0, 3'd1, 8'h00);

        // downstream stall for 5 cycles, with a stray response in REQ
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
        if_addr = 64'h1000; if_req_valid = 1'b1;
        #1 chk("stall grant if", 64'(if_req_ready), 64'd1);
        @(negedge clk);
        ls_req_valid = 1'b1; ls_wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("stall%0d mem_req_valid", i), 64'(mem_req_valid), 64'd1);
            chk($sformatf("stall%0d mem_addr", i), mem_addr, 64'h1000);
            chk($sformatf("stall%0d readies", i), 64'({if_req_ready, ls_req_ready}), 64'd0);
            chk($sformatf("stall%0d rsp", i), 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("wait mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("wait if_rsp", 64'(if_rsp_valid), 64'd0);

        // reset in WAIT drops the transaction
        rst_n = 1'b0;
        #1;
        chk("rstw mem_addr", mem_addr, 64'd0);
        chk("rstw if_rdata", if_rdata, 64'd0);
        chk("rstw ls_rdata", ls_rdata, 64'd0);
        chk("rstw mem_wen", 64'(mem_wen), 64'd0);
        chk("rstw rsp", 64'({if_rsp_valid, ls_rsp_valid, mem_req_valid}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk($sformatf("post-rst%0d outputs", i),
                   64'({if_rsp_valid, ls_rsp_valid, mem_req_valid}), 64'd0);
        end
        mem_rsp_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 if_req_valid  input  1  fetch read request.
REQ-005 if_req_ready  output  1  fetch request accepted this cycle.
REQ-006 if_addr  input  64  fetch address.
REQ-007 if_rsp_valid  output  1  one-cycle fetch response strobe.
REQ-008 if_rdata  output  64  fetch read data.
REQ-009 ls_req_valid  input  1  load/store request.
REQ-010 ls_req_ready  output  1  load/store request accepted this cycle.
REQ-011 ls_addr  input  64  load/store address.
REQ-012 ls_wen  input  1  1 = store, 0 = load.
REQ-013 ls_wdata  input  64  store data.
REQ-014 ls_memop  input  3  access size: 1 = 8B, 2 = 4B, 3 = 2B, 4 = 1B, others = no bytes.
REQ-015 ls_rsp_valid  output  1  one-cycle load/store response strobe.
REQ-016 ls_rdata  output  64  load data.
REQ-017 mem_req_valid, mem_req_ready  output/input  1  downstream request handshake.
REQ-018 mem_addr, mem_wdata  output  64  downstream address and write data.
REQ-019 mem_wen  output  1; mem_wmask  output  8  downstream write enable and byte mask.
REQ-020 mem_rsp_valid  input  1; mem_rdata  input  64  downstream response.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, RESP; exactly one transaction is outstanding at a time.
REQ-022 IDLE: if any req_valid, grant one requester; its req_ready SHALL be 1 combinationally that cycle; the other ready SHALL be 0.
REQ-023 In all non-IDLE states both req_ready SHALL be 0.
REQ-024 Arbitration SHALL be round-robin on a 1-bit last_grant: on simultaneous requests the requester not last granted wins; a lone request always wins.
REQ-025 At grant, addr/wen/wdata/wmask SHALL be latched; FSM goes to REQ next cycle.
REQ-026 Fetch grants SHALL drive mem_wen = 0 and mem_wmask = 8'h00.
REQ-027 REQ: mem_req_valid = 1 with stable latched fields until mem_req_ready = 1; then go to WAIT.
REQ-028 WAIT: on mem_rsp_valid = 1, latch mem_rdata and go to RESP; mem_rsp_valid in any other state SHALL be ignored.
REQ-029 RESP: the owner's rsp_valid = 1 for exactly one cycle, its rdata = latched data; then go to IDLE, which can grant that same cycle's requests on the next edge.
REQ-030 Stores SHALL also produce a response strobe; ls_rdata then carries whatever mem_rdata was latched.
REQ-031 wmask SHALL be 8'hFF for memop 1; for memop 2/3/4 it SHALL be 8'h0F/8'h03/8'h01 shifted left by ls_addr[2:0]; shifted-out bits are dropped; loads SHALL drive 8'h00.
REQ-032 Minimum latency, grant to rsp_valid, with mem_req_ready and mem_rsp_valid both 1 at first opportunity: 3 cycles.
REQ-033 rdata outputs SHALL hold their value between responses.

Reset
REQ-034 On rst_n = 0, the FSM SHALL go to IDLE, last_grant = fetch (so LSU wins first contention), and all outputs and latched registers SHALL be 0.
REQ-035 Reset mid-transaction SHALL drop the transaction; no response is issued after release.

Structure
REQ-036 The FSM state enum, memop encodings and last-grant encoding SHALL live in a shared package, mem_pkg.
REQ-037 wmask decode SHALL be a sub-module, wmask_gen (memop, addr[2:0] -> 8-bit mask).

Verification
REQ-038 Fetch read 0x80000000, mem_rdata = 0x1122334455667788, ready/rsp immediate -> if_rsp_valid 3 cycles after grant, if_rdata = 0x1122334455667788.
REQ-039 Both requesting at time 0 after reset -> LSU granted first, then fetch; with both held, grants alternate LS, IF, LS.
REQ-040 Store memop 4, addr 0x80000003 -> mem_wen = 1, mem_wmask = 8'h08; memop 1 -> 8'hFF; memop 0 -> 8'h00.
REQ-041 mem_req_ready held 0 for 5 cycles -> mem_req_valid and mem_addr stable throughout, both req_ready = 0.
REQ-042 Stray mem_rsp_valid in IDLE/REQ -> no rsp_valid; rst_n pulsed low in WAIT -> outputs 0, no response after release.
